// File: rtl/fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_if
//
// Purpose: groups the producer-side valid/ready/data bundle and the FIFO
// write-port signals that the write arbiter sits between.
//
// Signals:
//   req_valid         producers -> arbiter  bit i: requester i offers a word
//   req_data          producers -> arbiter  word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         arbiter -> producers  one-hot or zero take strobe
//   fifo_full         FIFO -> arbiter       FIFO full flag
//   fifo_almost_full  FIFO -> arbiter       exactly one free slot left
//   fifo_write_enable arbiter -> FIFO       registered write strobe
//   fifo_data         arbiter -> FIFO       registered write data
//   grant_id          arbiter -> FIFO side  requester that owns fifo_data
//   busy              arbiter -> system     any request pending or write in flight
//
// Modports:
//   master  the arbiter itself (drives ready and the FIFO write port)
//   slave   the producers and FIFO model around it
// ---------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int REQ_BITS   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almost_full;
  logic                          fifo_write_enable;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic [REQ_BITS-1:0]           grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_almost_full,
    output req_ready, fifo_write_enable, fifo_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_almost_full,
    input  req_ready, fifo_write_enable, fifo_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Purpose: round-robin arbiter sharing the single write port of the
// dual-clock FIFO between NUM_REQ producers in the write_clock domain.
// One word is taken per cycle and presented to the FIFO from registers.
// Writes are suppressed while the FIFO is full or while the in-flight write
// is about to consume the last free slot.
//
// Ports:
//   write_clock  clock, rising edge
//   reset        synchronous, active-high reset
//   bus          fifo_write_arbiter_if.master (request bundle + FIFO write port)
//
// Configuration:
//   FIFO_ARB_BURST_EN  when defined, a granted requester keeps priority for
//                      up to BURST_LEN consecutive transfers while it stays
//                      valid; otherwise pure round-robin.
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int REQ_BITS   = 2,
  parameter int BURST_LEN  = 4
) (
  input  logic                 write_clock,
  input  logic                 reset,
  fifo_write_arbiter_if.master bus
);

  logic [REQ_BITS-1:0]   last_grant_q, last_grant_d;
  logic                  fifo_write_enable_q, fifo_write_enable_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [REQ_BITS-1:0]   grant_id_q, grant_id_d;

`ifdef FIFO_ARB_BURST_EN
  logic [3:0] burst_cnt_q, burst_cnt_d;
  // Set by any transfer; marks that last_grant_q names a live burst owner
  // (not merely the reset pointer value).
  logic       burst_hold_q, burst_hold_d;
  logic       keep;
`endif

  logic                space_ok;
  logic                any_valid;
  logic                found;
  logic                xfer;
  logic [REQ_BITS-1:0] cand;
  logic [REQ_BITS-1:0] sel;
  logic [NUM_REQ-1:0]  ready;

  // The write already in flight consumes the last slot when almost_full.
  assign space_ok  = ~bus.fifo_full & ~(fifo_write_enable_q & bus.fifo_almost_full);
  assign any_valid = |bus.req_valid;

`ifdef FIFO_ARB_BURST_EN
  assign keep = burst_hold_q & bus.req_valid[last_grant_q]
              & (burst_cnt_q < 4'(BURST_LEN - 1));
`endif

  // Rotating priority search: last_grant+1 first, last_grant itself last.
  // Only valid, state and flag inputs feed this, never req_data.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = REQ_BITS'((int'(last_grant_q) + i + 1) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
`ifdef FIFO_ARB_BURST_EN
    if (keep) sel = last_grant_q;
`endif
  end

  always_comb begin
    ready = '0;
    if (space_ok && any_valid && !reset) ready[sel] = 1'b1;
  end

  // sel always points at a valid requester when ready is raised.
  assign xfer = |ready;

  always_comb begin
    last_grant_d        = last_grant_q;
    fifo_data_d         = fifo_data_q;
    grant_id_d          = grant_id_q;
    fifo_write_enable_d = xfer;
    if (xfer) begin
      last_grant_d = sel;
      fifo_data_d  = bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      grant_id_d   = sel;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_comb begin
    burst_cnt_d  = burst_cnt_q;
    burst_hold_d = burst_hold_q;
    if (xfer) begin
      burst_hold_d = 1'b1;
      // Retained transfer extends the burst; anything else (new owner, or
      // owner re-won after its burst expired) starts a fresh count.
      burst_cnt_d  = (keep && sel == last_grant_q) ? burst_cnt_q + 4'd1 : 4'd0;
    end else if (burst_hold_q && !bus.req_valid[last_grant_q]) begin
      // Owner dropped valid: burst over, search resumes from owner+1.
      burst_hold_d = 1'b0;
      burst_cnt_d  = 4'd0;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge write_clock) begin
    if (reset) begin
      // NOTE: the data register is reset too; it is a single output word,
      // not a storage array, and a known 0 keeps the FIFO port clean.
      last_grant_q        <= REQ_BITS'(NUM_REQ - 1);
      fifo_write_enable_q <= 1'b0;
      fifo_data_q         <= '0;
      grant_id_q          <= '0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q         <= 4'd0;
      burst_hold_q        <= 1'b0;
`endif
    end else begin
      last_grant_q        <= last_grant_d;
      fifo_write_enable_q <= fifo_write_enable_d;
      fifo_data_q         <= fifo_data_d;
      grant_id_q          <= grant_id_d;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q         <= burst_cnt_d;
      burst_hold_q        <= burst_hold_d;
`endif
    end
  end

  assign bus.req_ready         = ready;
  assign bus.fifo_write_enable = fifo_write_enable_q;
  assign bus.fifo_data         = fifo_data_q;
  assign bus.grant_id          = grant_id_q;
  assign bus.busy              = any_valid | fifo_write_enable_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Directed bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=32).
// Inputs change on the falling edge; req_ready is sampled 1 ns later, before
// the rising edge that uses it; registered outputs are sampled on the
// following falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int RB = 2;

  logic write_clock;
  logic reset;

  int tests_run;
  int tests_failed;

  fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .REQ_BITS(RB)) bus_if ();

  fifo_write_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .REQ_BITS(RB), .BURST_LEN(4)
  ) dut (
    .write_clock (write_clock),
    .reset       (reset),
    .bus         (bus_if)
  );

  initial begin
    write_clock = 1'b0;
    forever #5 write_clock = ~write_clock;
  end

  task automatic apply_reset();
    @(negedge write_clock);
    reset                   = 1'b1;
    bus_if.req_valid        = '0;
    bus_if.req_data         = '0;
    bus_if.fifo_full        = 1'b0;
    bus_if.fifo_almost_full = 1'b0;
    @(posedge write_clock);
    @(negedge write_clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    // Reset held again with requests present: no ready, busy tracks valid.
    reset            = 1'b1;
    bus_if.req_valid = 4'b1010;
    #1;
    tests_run++;
    if (bus_if.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ready_in_reset: got %b expected 0000", bus_if.req_ready);
    end
    tests_run++;
    if (bus_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_busy_in_reset: got %b expected 1", bus_if.busy);
    end
    @(posedge write_clock);
    @(negedge write_clock);
    bus_if.req_valid = 4'b0000;
    reset            = 1'b0;
    #1;
    tests_run++;
    if (bus_if.req_ready !== 4'b0000 || bus_if.fifo_write_enable !== 1'b0 ||
        bus_if.fifo_data !== 32'h0 || bus_if.grant_id !== 2'd0 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b we=%b data=%h gid=%0d busy=%b expected 0000 0 0 0 0",
               bus_if.req_ready, bus_if.fifo_write_enable, bus_if.fifo_data,
               bus_if.grant_id, bus_if.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    apply_reset();
    bus_if.req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) bus_if.req_data[i*DW +: DW] = 32'h100 + i;
    for (int k = 0; k < 8; k++) begin
      g = 2'(k % 4);
      #1;
      tests_run++;
      if (bus_if.req_ready !== (4'b0001 << g)) begin
        tests_failed++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", k, bus_if.req_ready, 4'b0001 << g);
      end
      @(posedge write_clock);
      @(negedge write_clock);
      tests_run++;
      if (bus_if.fifo_write_enable !== 1'b1 || bus_if.grant_id !== g ||
          bus_if.fifo_data !== 32'h100 + 32'(g)) begin
        tests_failed++;
        $display("FAIL rr_write[%0d]: we=%b gid=%0d data=%h expected 1 %0d %h",
                 k, bus_if.fifo_write_enable, bus_if.grant_id, bus_if.fifo_data, g, 32'h100 + 32'(g));
      end
    end
    bus_if.req_valid = '0;
  endtask

  task automatic test_burst();
    logic [1:0] exp_g [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    apply_reset();
    bus_if.req_valid = 4'b0011;
    bus_if.req_data[0*DW +: DW] = 32'hB0;
    bus_if.req_data[1*DW +: DW] = 32'hB1;
    for (int k = 0; k < 10; k++) begin
      #1;
      tests_run++;
      if (bus_if.req_ready !== (4'b0001 << exp_g[k])) begin
        tests_failed++;
        $display("FAIL burst_ready[%0d]: got %b expected %b", k, bus_if.req_ready, 4'b0001 << exp_g[k]);
      end
      @(posedge write_clock);
      @(negedge write_clock);
      tests_run++;
      if (bus_if.fifo_write_enable !== 1'b1 || bus_if.grant_id !== exp_g[k]) begin
        tests_failed++;
        $display("FAIL burst_grant[%0d]: we=%b gid=%0d expected 1 %0d",
                 k, bus_if.fifo_write_enable, bus_if.grant_id, exp_g[k]);
      end
    end
    bus_if.req_valid = '0;
  endtask

  task automatic test_single_requester();
    apply_reset();
    bus_if.req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      bus_if.req_data[2*DW +: DW] = 32'hA0 + k;
      #1;
      tests_run++;
      if (bus_if.req_ready !== 4'b0100) begin
        tests_failed++;
        $display("FAIL single_ready[%0d]: got %b expected 0100", k, bus_if.req_ready);
      end
      @(posedge write_clock);
      @(negedge write_clock);
      tests_run++;
      if (bus_if.fifo_write_enable !== 1'b1 || bus_if.grant_id !== 2'd2 ||
          bus_if.fifo_data !== 32'hA0 + k) begin
        tests_failed++;
        $display("FAIL single_write[%0d]: we=%b gid=%0d data=%h expected 1 2 %h",
                 k, bus_if.fifo_write_enable, bus_if.grant_id, bus_if.fifo_data, 32'hA0 + k);
      end
    end
    bus_if.req_valid            = 4'b0000;
    bus_if.req_data[2*DW +: DW] = 32'hFF;
    @(posedge write_clock);
    @(negedge write_clock);
    tests_run++;
    if (bus_if.fifo_write_enable !== 1'b0 || bus_if.fifo_data !== 32'hA2 ||
        bus_if.grant_id !== 2'd2 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle_hold: we=%b data=%h gid=%0d busy=%b expected 0 a2 2 0",
               bus_if.fifo_write_enable, bus_if.fifo_data, bus_if.grant_id, bus_if.busy);
    end
  endtask

  task automatic test_almost_full();
    apply_reset();
    bus_if.req_valid            = 4'b0001;
    bus_if.req_data[0*DW +: DW] = 32'hC0;
    @(posedge write_clock);               // write of C0 issued
    @(negedge write_clock);
    bus_if.fifo_almost_full = 1'b1;       // C0 in flight takes the last slot
    #1;
    tests_run++;
    if (bus_if.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL af_inflight_ready: got %b expected 0000", bus_if.req_ready);
    end
    @(posedge write_clock);
    @(negedge write_clock);
    tests_run++;
    if (bus_if.fifo_write_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL af_no_write: got we=%b expected 0", bus_if.fifo_write_enable);
    end
    bus_if.fifo_full        = 1'b1;
    bus_if.fifo_almost_full = 1'b0;
    #1;
    tests_run++;
    if (bus_if.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL full_ready: got %b expected 0000", bus_if.req_ready);
    end
    @(posedge write_clock);
    @(negedge write_clock);
    // Full clears with one slot free: exactly one more write.
    bus_if.fifo_full            = 1'b0;
    bus_if.fifo_almost_full     = 1'b1;
    bus_if.req_data[0*DW +: DW] = 32'hC1;
    #1;
    tests_run++;
    if (bus_if.req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL af_last_slot_ready: got %b expected 0001", bus_if.req_ready);
    end
    @(posedge write_clock);
    @(negedge write_clock);
    tests_run++;
    if (bus_if.fifo_write_enable !== 1'b1 || bus_if.fifo_data !== 32'hC1) begin
      tests_failed++;
      $display("FAIL af_last_slot_write: we=%b data=%h expected 1 c1",
               bus_if.fifo_write_enable, bus_if.fifo_data);
    end
    #1;
    tests_run++;
    if (bus_if.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL af_after_last_ready: got %b expected 0000", bus_if.req_ready);
    end
    @(posedge write_clock);
    @(negedge write_clock);
    tests_run++;
    if (bus_if.fifo_write_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL af_after_last_write: got we=%b expected 0", bus_if.fifo_write_enable);
    end
    bus_if.req_valid        = '0;
    bus_if.fifo_almost_full = 1'b0;
  endtask

  task automatic test_stall_pointer();
    logic [1:0] exp_g;
`ifdef FIFO_ARB_BURST_EN
    exp_g = 2'd0;   // requester 0 still owns its burst
`else
    exp_g = 2'd1;
`endif
    apply_reset();
    bus_if.req_valid = 4'b0001;
    @(posedge write_clock);               // grant 0
    @(negedge write_clock);
    bus_if.fifo_full = 1'b1;
    bus_if.req_valid = 4'b1111;
    @(posedge write_clock);               // stall
    @(negedge write_clock);
    tests_run++;
    if (bus_if.fifo_write_enable !== 1'b0 || bus_if.grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL stall_hold: we=%b gid=%0d expected 0 0",
               bus_if.fifo_write_enable, bus_if.grant_id);
    end
    bus_if.fifo_full = 1'b0;
    #1;
    tests_run++;
    if (bus_if.req_ready !== (4'b0001 << exp_g)) begin
      tests_failed++;
      $display("FAIL stall_pointer_ready: got %b expected %b", bus_if.req_ready, 4'b0001 << exp_g);
    end
    @(posedge write_clock);
    @(negedge write_clock);
    tests_run++;
    if (bus_if.grant_id !== exp_g || bus_if.fifo_write_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_pointer_grant: gid=%0d we=%b expected %0d 1",
               bus_if.grant_id, bus_if.fifo_write_enable, exp_g);
    end
    bus_if.req_valid = '0;
  endtask

  task automatic test_reset_mid_stream();
    apply_reset();
    bus_if.req_valid = 4'b1010;
    bus_if.req_data[1*DW +: DW] = 32'hD1;
    bus_if.req_data[3*DW +: DW] = 32'hD3;
    @(posedge write_clock);               // grant 1
    @(negedge write_clock);
    tests_run++;
    if (bus_if.grant_id !== 2'd1 || bus_if.fifo_data !== 32'hD1) begin
      tests_failed++;
      $display("FAIL midrst_pre: gid=%0d data=%h expected 1 d1", bus_if.grant_id, bus_if.fifo_data);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus_if.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midrst_ready: got %b expected 0000", bus_if.req_ready);
    end
    @(posedge write_clock);
    @(negedge write_clock);
    tests_run++;
    if (bus_if.fifo_write_enable !== 1'b0 || bus_if.fifo_data !== 32'h0 ||
        bus_if.grant_id !== 2'd0 || bus_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_outputs: we=%b data=%h gid=%0d busy=%b expected 0 0 0 1",
               bus_if.fifo_write_enable, bus_if.fifo_data, bus_if.grant_id, bus_if.busy);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus_if.req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL midrst_first_ready: got %b expected 0010", bus_if.req_ready);
    end
    @(posedge write_clock);
    @(negedge write_clock);
    tests_run++;
    if (bus_if.grant_id !== 2'd1 || bus_if.fifo_write_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_first_grant: gid=%0d we=%b expected 1 1",
               bus_if.grant_id, bus_if.fifo_write_enable);
    end
    bus_if.req_valid = '0;
  endtask

  initial begin
    tests_run               = 0;
    tests_failed            = 0;
    reset                   = 1'b1;
    bus_if.req_valid        = '0;
    bus_if.req_data         = '0;
    bus_if.fifo_full        = 1'b0;
    bus_if.fifo_almost_full = 1'b0;

    test_reset();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`else
    test_round_robin();
`endif
    test_single_requester();
    test_almost_full();
    test_stall_pointer();
    test_reset_mid_stream();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
